// File: rtl/video_pkg.sv
//==============================================================================
// Module      : video_pkg
// Description : Shared constants and helpers for the video pre-processing path.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package video_pkg;

    // Out-of-image tap handling
    localparam int BORDER_ZERO = 0;
    localparam int BORDER_REPL = 1;

    // Ceiling log2, used to size address and counter fields
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/line_ram_sdp.sv
//==============================================================================
// Module      : line_ram_sdp
// Description : Simple dual-port line RAM, one write port, one read port with
//               a registered (1-cycle) read. Read-first on address collision.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module line_ram_sdp
    import video_pkg::*;
#(
    parameter int DEPTH    = 1920,
    parameter int DATA_W   = 8,
    localparam int C_ADDR_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH)
) (
    input  logic                video_clk,
    input  logic                we,
    input  logic [C_ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [C_ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Storage array with registered read; no reset so it maps onto block RAM
    always_ff @(posedge video_clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        r_rdata <= r_mem[raddr];
    end

    assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/matrix_kxk.sv
//==============================================================================
// Module      : matrix_kxk
// Description : KxK sliding-window generator. Buffers KSIZE-1 lines, applies
//               top/left border fill and emits one window per accepted pixel
//               with a fixed 2-cycle latency.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module matrix_kxk
    import video_pkg::*;
#(
    parameter int KSIZE       = 3,
    parameter int DATA_W      = 8,
    parameter int IMG_WIDTH   = 1920,
    parameter int BORDER_MODE = 0
) (
    input  logic                            video_clk,
    input  logic                            rst_n,
    input  logic                            video_vs,
    input  logic                            video_de,
    input  logic [DATA_W-1:0]               video_data,
    output logic                            matrix_vs,
    output logic                            matrix_de,
    output logic [KSIZE*KSIZE*DATA_W-1:0]   matrix_data
);

    localparam int C_ADDR_W = (clog2(IMG_WIDTH) < 1) ? 1 : clog2(IMG_WIDTH);
    localparam int C_XCNT_W = clog2(IMG_WIDTH + 1);
    localparam int C_YCNT_W = clog2(KSIZE);
    localparam logic [C_XCNT_W-1:0] C_XMAX = C_XCNT_W'(IMG_WIDTH);
    localparam logic [C_YCNT_W-1:0] C_YMAX = C_YCNT_W'(KSIZE - 1);

    // Input-side frame/line tracking
    logic                r_vs_d;
    logic                r_de_d;
    logic [C_XCNT_W-1:0] r_x_cnt;
    logic [C_YCNT_W-1:0] r_y_cnt;

    // Stage 1: RAM read in flight, sample metadata
    logic                r_acc_d1;
    logic                r_x0_d1;
    logic [C_YCNT_W-1:0] r_y_d1;
    logic [DATA_W-1:0]   r_pix_d1;
    logic [C_ADDR_W-1:0] r_waddr_d1;

    // Stage 2: window and output strobes
    logic                                     r_matrix_vs;
    logic                                     r_matrix_de;
    logic [KSIZE-1:0][KSIZE-1:0][DATA_W-1:0]  r_win;

    logic                w_vs_rise;
    logic                w_de_fall;
    logic [C_XCNT_W-1:0] w_x_eff;
    logic [C_YCNT_W-1:0] w_y_eff;
    logic                w_accept;

    // w_col[j] is the column sample from line y-j; w_col[0] is the live pixel
    logic [DATA_W-1:0]   w_col  [KSIZE];
    logic [DATA_W-1:0]   w_samp [KSIZE];

    // A frame-sync rising edge wins over everything: that pixel is x=0, y=0
    assign w_vs_rise = video_vs & ~r_vs_d;
    assign w_de_fall = r_de_d & ~video_de;
    assign w_x_eff   = w_vs_rise ? '0 : r_x_cnt;
    assign w_y_eff   = w_vs_rise ? '0 : r_y_cnt;
    assign w_accept  = video_de && (w_x_eff < C_XMAX);

    // Pixel/line counters; y saturates since only 0..KSIZE-1 affects border fill
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_d  <= 1'b0;
            r_de_d  <= 1'b0;
            r_x_cnt <= '0;
            r_y_cnt <= '0;
        end else begin
            r_vs_d <= video_vs;
            r_de_d <= video_de;
            if (w_vs_rise) begin
                r_x_cnt <= w_accept ? C_XCNT_W'(1) : '0;
                r_y_cnt <= '0;
            end else if (w_de_fall) begin
                r_x_cnt <= '0;
                if (r_y_cnt != C_YMAX) begin
                    r_y_cnt <= r_y_cnt + C_YCNT_W'(1);
                end
            end else if (w_accept) begin
                r_x_cnt <= r_x_cnt + C_XCNT_W'(1);
            end
        end
    end

    // Stage-1 pipeline: carry the pixel and its position alongside the RAM read
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_d1   <= 1'b0;
            r_x0_d1    <= 1'b0;
            r_y_d1     <= '0;
            r_pix_d1   <= '0;
            r_waddr_d1 <= '0;
        end else begin
            r_acc_d1   <= w_accept;
            r_x0_d1    <= (w_x_eff == '0);
            r_y_d1     <= w_y_eff;
            r_pix_d1   <= video_data;
            r_waddr_d1 <= w_x_eff[C_ADDR_W-1:0];
        end
    end

    assign w_col[0] = r_pix_d1;

    // Cascaded line RAMs: RAM i is read for pixel x, then rewritten one cycle
    // later at the same address with the sample just read from RAM i-1
    generate
        for (genvar i = 0; i < KSIZE - 1; i++) begin : g_line_ram
            line_ram_sdp #(
                .DEPTH  (IMG_WIDTH),
                .DATA_W (DATA_W)
            ) u_line_ram (
                .video_clk (video_clk),
                .we        (r_acc_d1),
                .waddr     (r_waddr_d1),
                .wdata     (w_col[i]),
                .raddr     (w_x_eff[C_ADDR_W-1:0]),
                .rdata     (w_col[i+1])
            );
        end
    endgenerate

    // Top-border mux: rows above line 0 become zero or repeat line 0
    always_comb begin
        for (int r = 0; r < KSIZE; r++) begin
            w_samp[r] = '0;
            if (C_YCNT_W'(KSIZE - 1 - r) <= r_y_d1) begin
                w_samp[r] = w_col[KSIZE-1-r];
            end else if (BORDER_MODE == BORDER_REPL) begin
                w_samp[r] = w_col[r_y_d1];
            end
        end
    end

    // Row shift registers double as the output register; left border preload at x=0
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win       <= '0;
            r_matrix_de <= 1'b0;
            r_matrix_vs <= 1'b0;
        end else begin
            r_matrix_de <= r_acc_d1;
            r_matrix_vs <= r_vs_d;
            if (r_acc_d1) begin
                for (int r = 0; r < KSIZE; r++) begin
                    if (r_x0_d1) begin
                        for (int c = 0; c < KSIZE; c++) begin
                            if ((BORDER_MODE == BORDER_REPL) || (c == KSIZE - 1)) begin
                                r_win[r][c] <= w_samp[r];
                            end else begin
                                r_win[r][c] <= '0;
                            end
                        end
                    end else begin
                        for (int c = 0; c < KSIZE - 1; c++) begin
                            r_win[r][c] <= r_win[r][c+1];
                        end
                        r_win[r][KSIZE-1] <= w_samp[r];
                    end
                end
            end
        end
    end

    assign matrix_vs   = r_matrix_vs;
    assign matrix_de   = r_matrix_de;
    assign matrix_data = r_win;

endmodule

`default_nettype wire
